// File: rtl/sprite_fetch_arbiter.sv
// Round-robin arbiter that lends the shared sprite-graphic lookup to one renderer at a time,
// raster-scans the whole tile through it and streams the registered pixels out with backpressure.
module sprite_fetch_arbiter #(
  parameter int unsigned NUM_REQ          = 4,
  parameter int unsigned REL_BITS         = 4,
  parameter int unsigned PIXELS_WIDTH     = 16,
  parameter int unsigned PIXEL_COLOR_BITS = 8,
  localparam int unsigned IdBits          = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_REQ-1:0]          req,
  output logic [NUM_REQ-1:0]          grant,
  output logic [REL_BITS-1:0]         gfx_x,
  output logic [REL_BITS-1:0]         gfx_y,
  input  logic [PIXEL_COLOR_BITS-1:0] gfx_pixels,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [PIXEL_COLOR_BITS-1:0] out_pixel,
  output logic [REL_BITS-1:0]         out_x,
  output logic [REL_BITS-1:0]         out_y,
  output logic [IdBits-1:0]           out_id,
  output logic                        out_last,
  output logic [NUM_REQ-1:0]          done
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StScan  = 2'd1;
  localparam logic [1:0] StFlush = 2'd2;

  localparam logic [REL_BITS-1:0] MaxCoord  = REL_BITS'(PIXELS_WIDTH - 1);
  localparam logic [REL_BITS-1:0] CoordOne  = REL_BITS'(1);
  localparam logic [NUM_REQ-1:0]  GrantOne  = NUM_REQ'(1);
  localparam logic [IdBits-1:0]   LastIndex = IdBits'(NUM_REQ - 1);

  logic [1:0]                  state_q, state_d;
  logic [NUM_REQ-1:0]          grant_q, grant_d;
  logic [NUM_REQ-1:0]          done_q, done_d;
  logic [IdBits-1:0]           rr_q, rr_d;
  logic [IdBits-1:0]           out_id_q, out_id_d;
  logic [REL_BITS-1:0]         scan_x_q, scan_x_d;
  logic [REL_BITS-1:0]         scan_y_q, scan_y_d;
  logic                        out_valid_q, out_valid_d;
  logic                        out_last_q, out_last_d;
  logic [PIXEL_COLOR_BITS-1:0] out_pixel_q, out_pixel_d;
  logic [REL_BITS-1:0]         out_x_q, out_x_d;
  logic [REL_BITS-1:0]         out_y_q, out_y_d;

  logic [IdBits-1:0] sel;
  logic [IdBits-1:0] cand;
  logic              found;
  int unsigned       idx;
  logic              adv;
  logic              at_x_end;
  logic              at_last;

  // Search starts one past the last owner so every waiting requester is served before a repeat.
  always_comb begin
    sel   = '0;
    cand  = '0;
    found = 1'b0;
    idx   = 0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      idx  = (32'(rr_q) + i) % NUM_REQ;
      cand = idx[IdBits-1:0];
      if (!found && req[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
    end
  end

  assign adv      = !out_valid_q || out_ready;
  assign at_x_end = (scan_x_q == MaxCoord);
  assign at_last  = at_x_end && (scan_y_q == MaxCoord);

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    done_d      = '0;
    rr_d        = rr_q;
    out_id_d    = out_id_q;
    scan_x_d    = scan_x_q;
    scan_y_d    = scan_y_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_pixel_d = out_pixel_q;
    out_x_d     = out_x_q;
    out_y_d     = out_y_q;

    case (state_q)
      StIdle: begin
        if (found) begin
          grant_d  = GrantOne << sel;
          out_id_d = sel;
          rr_d     = sel;
          scan_x_d = '0;
          scan_y_d = '0;
          state_d  = StScan;
        end
      end

      StScan: begin
        if (adv) begin
          out_pixel_d = gfx_pixels;
          out_x_d     = scan_x_q;
          out_y_d     = scan_y_q;
          out_valid_d = 1'b1;
          out_last_d  = at_last;
          if (at_last) begin
            scan_x_d = '0;
            scan_y_d = '0;
            state_d  = StFlush;
          end else if (at_x_end) begin
            scan_x_d = '0;
            scan_y_d = scan_y_q + CoordOne;
          end else begin
            scan_x_d = scan_x_q + CoordOne;
          end
        end
      end

      StFlush: begin
        // Only the final beat can be pending here; its acceptance ends the grant.
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          done_d      = grant_q;
          grant_d     = '0;
          state_d     = StIdle;
        end
      end

      default: begin
        grant_d     = '0;
        out_valid_d = 1'b0;
        out_last_d  = 1'b0;
        state_d     = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      grant_q     <= '0;
      done_q      <= '0;
      rr_q        <= LastIndex;
      out_id_q    <= '0;
      scan_x_q    <= '0;
      scan_y_q    <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_pixel_q <= '0;
      out_x_q     <= '0;
      out_y_q     <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      done_q      <= done_d;
      rr_q        <= rr_d;
      out_id_q    <= out_id_d;
      scan_x_q    <= scan_x_d;
      scan_y_q    <= scan_y_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_pixel_q <= out_pixel_d;
      out_x_q     <= out_x_d;
      out_y_q     <= out_y_d;
    end
  end

  assign grant     = grant_q;
  assign done      = done_q;
  assign gfx_x     = scan_x_q;
  assign gfx_y     = scan_y_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_pixel = out_pixel_q;
  assign out_x     = out_x_q;
  assign out_y     = out_y_q;
  assign out_id    = out_id_q;

endmodule

// File: tb/tb_sprite_fetch_arbiter.sv
// Randomised bench for sprite_fetch_arbiter against a transaction-level model: round-robin pick,
// raster-ordered expected beat queue per grant, done after the last accepted beat.
module tb_sprite_fetch_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] grant;
  logic [3:0] gfx_x;
  logic [3:0] gfx_y;
  logic [7:0] gfx_pixels;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_pixel;
  logic [3:0] out_x;
  logic [3:0] out_y;
  logic [1:0] out_id;
  logic       out_last;
  logic [3:0] done;

  sprite_fetch_arbiter #(
    .NUM_REQ         (4),
    .REL_BITS        (4),
    .PIXELS_WIDTH    (16),
    .PIXEL_COLOR_BITS(8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .grant     (grant),
    .gfx_x     (gfx_x),
    .gfx_y     (gfx_y),
    .gfx_pixels(gfx_pixels),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pixel (out_pixel),
    .out_x     (out_x),
    .out_y     (out_y),
    .out_id    (out_id),
    .out_last  (out_last),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] id;
    logic [3:0] x;
    logic [3:0] y;
    logic [7:0] pix;
    logic       last;
  } beat_t;

  int    n_cmp;
  int    n_mis;
  int    mode;
  int    salt;
  beat_t exp_q[$];
  int    served[$];
  bit    m_busy;
  int    m_owner;
  int    m_rr;
  int    since;
  int    beats;
  int    scan_len;
  int    n_done;

  function automatic logic [7:0] gfx_f(input int md, input int sl, input logic [3:0] x,
                                       input logic [3:0] y);
    case (md)
      0:       return 8'hFF;
      1:       return {y, x};
      default: return 8'((int'(x) * 37 + int'(y) * 11 + sl) & 255);
    endcase
  endfunction

  always_comb gfx_pixels = gfx_f(mode, salt, gfx_x, gfx_y);

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_mis++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, got, want, $time);
    end
  endtask

  function automatic int pick(input logic [3:0] r);
    for (int i = 1; i <= 4; i++) begin
      int k = (m_rr + i) % 4;
      if (r[k]) return k;
    end
    return -1;
  endfunction

  task automatic fill(input int id);
    for (int y = 0; y < 16; y++) begin
      for (int x = 0; x < 16; x++) begin
        beat_t b;
        b.id   = 2'(id);
        b.x    = 4'(x);
        b.y    = 4'(y);
        b.pix  = gfx_f(mode, salt, 4'(x), 4'(y));
        b.last = (x == 15) && (y == 15);
        exp_q.push_back(b);
      end
    end
  endtask

  function automatic logic rdy_gen(input int rmode, input int k);
    case (rmode)
      0:       return 1'b1;
      1:       return (k % 2) == 0;
      default: return $urandom_range(0, 3) != 0;
    endcase
  endfunction

  // One clock: called at a falling edge, drives inputs, predicts the next rising edge, then
  // checks the result at the following falling edge.
  task automatic cycle(input logic [3:0] r, input logic rdy);
    logic [24:0] snap;
    bit          stall;
    bit          exp_done;
    int          p;
    req       = r;
    out_ready = rdy;
    snap      = {out_pixel, out_x, out_y, out_last, gfx_x, gfx_y};
    stall     = out_valid && !rdy;
    exp_done  = 0;
    if (out_valid && rdy) begin
      if (exp_q.size() == 0) begin
        check_eq("extra_beat", 1, 0);
      end else begin
        beat_t e;
        e = exp_q.pop_front();
        check_eq("beat", {out_id, out_x, out_y, out_pixel, out_last}, e);
        beats++;
        if (e.last) exp_done = 1;
      end
    end
    p = m_busy ? -1 : pick(r);
    @(negedge clk);
    if (m_busy) since++;
    if (exp_done) begin
      check_eq("done", done, 64'(1) << m_owner);
      check_eq("grant_release", grant, 0);
      m_busy   = 0;
      scan_len = since;
      n_done++;
    end else begin
      check_eq("done_quiet", done, 0);
      if (p >= 0) begin
        check_eq("grant", grant, 64'(1) << p);
        check_eq("valid_at_grant", out_valid, 0);
        m_owner = p;
        m_rr    = p;
        m_busy  = 1;
        since   = 0;
        beats   = 0;
        fill(p);
        served.push_back(p);
      end else if (m_busy) begin
        check_eq("grant_hold", grant, 64'(1) << m_owner);
        if (since == 1) check_eq("first_valid", out_valid, 1);
      end else begin
        check_eq("idle_grant", grant, 0);
        check_eq("idle_valid", out_valid, 0);
      end
    end
    if (stall) check_eq("stall_hold", {out_pixel, out_x, out_y, out_last, gfx_x, gfx_y}, snap);
  endtask

  task automatic run(input logic [3:0] r, input int rmode, input int ndone, input int budget);
    int target;
    int k;
    target = n_done + ndone;
    k      = 0;
    while (n_done < target && k < budget) begin
      cycle(r, rdy_gen(rmode, k));
      k++;
    end
    if (n_done < target) check_eq("run_timeout", n_done, target);
  endtask

  task automatic model_reset();
    m_busy = 0;
    m_rr   = 3;
    exp_q.delete();
  endtask

  // Asserted between edges; called at a falling edge, returns at a falling edge.
  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst_grant", grant, 0);
    check_eq("rst_valid", out_valid, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_last", out_last, 0);
    model_reset();
    req = '0;
    @(negedge clk);
    check_eq("rst_done_hold", done, 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    n_cmp     = 0;
    n_mis     = 0;
    mode      = 0;
    salt      = 0;
    n_done    = 0;
    since     = 0;
    beats     = 0;
    scan_len  = 0;
    m_owner   = 0;
    rst_n     = 1'b0;
    req       = '0;
    out_ready = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_eq("reset_outs", {grant, done, out_valid, out_last, out_pixel, out_x, out_y, out_id},
             0);
    check_eq("reset_gfx", {gfx_x, gfx_y}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: single requester, constant pixel, ready always high
    mode = 0;
    run(4'b0001, 0, 1, 400);
    check_eq("t1_owner", served[$], 0);
    check_eq("t1_scan_len", scan_len, 257);
    cycle(4'b0000, 1'b1);

    // 2: all requesting, rotation from a fresh reset
    do_reset();
    mode = 2;
    salt = int'($urandom_range(0, 255));
    run(4'b1111, 2, 5, 3000);
    for (int i = 0; i < 5; i++) check_eq("t2_order", served[served.size() - 5 + i], i % 4);
    cycle(4'b0000, 1'b1);

    // 3: alternating ready, pixel encodes its own coordinates
    mode = 1;
    run(4'b0001, 1, 1, 700);
    check_eq("t3_beats", beats, 256);
    check_eq("t3_queue_empty", exp_q.size(), 0);
    cycle(4'b0000, 1'b1);

    // 4: reset in the middle of requester 1's scan
    begin
      int k;
      k = 0;
      while (!(m_busy && m_owner == 1 && beats >= 100) && k < 400) begin
        cycle(4'b0010, 1'b1);
        k++;
      end
      check_eq("t4_reached_beat100", beats, 100);
    end
    do_reset();
    run(4'b0011, 0, 1, 400);
    check_eq("t4_first_after_reset", served[$], 0);
    cycle(4'b0000, 1'b1);

    // 5: one-cycle request still gets a full scan
    mode = 2;
    cycle(4'b0100, 1'b1);
    run(4'b0000, 2, 1, 700);
    check_eq("t5_owner", served[$], 2);
    check_eq("t5_beats", beats, 256);
    repeat (3) cycle(4'b0000, 1'b1);

    // 6: requester 3 re-requests straight after done while 1 waits
    run(4'b1010, 2, 2, 1400);
    check_eq("t6_first", served[served.size() - 2], 3);
    check_eq("t6_second", served[$], 1);
    cycle(4'b0000, 1'b1);

    // Random request masks and backpressure
    salt = int'($urandom_range(0, 255));
    for (int s = 0; s < 12; s++) begin
      logic [3:0] r;
      int         len;
      r   = 4'($urandom_range(0, 15));
      len = int'($urandom_range(20, 400));
      for (int k = 0; k < len; k++) cycle(r, rdy_gen(2, k));
    end
    begin
      int k;
      k = 0;
      while (m_busy && k < 1000) begin
        cycle(4'b0000, rdy_gen(2, k));
        k++;
      end
      check_eq("drain_idle", m_busy, 0);
    end
    repeat (3) cycle(4'b0000, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
